// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response and SRAM bus bundle
// shared by the pipeline requesters and the SRAM arbiter.
interface sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_resp_ready;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        data_resp_ready;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output inst_req, inst_addr, inst_resp_ready,
        output data_req, data_wr, data_wstrb,
        output data_addr, data_wdata, data_resp_ready,
        output sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  inst_req, inst_addr, inst_resp_ready,
        input  data_req, data_wr, data_wstrb,
        input  data_addr, data_wdata, data_resp_ready,
        input  sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: single-port SRAM shared by IF and EX,
// data-first with bounded fetch starvation.
module sram_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input logic       clk,
    input logic       reset,
    sram_arbiter_if.slave bus
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic        live;
    logic        fly_inst;
    logic        fly_data;
    logic        hold_inst_valid;
    logic        hold_data_valid;
    logic [31:0] hold_inst_data;
    logic [31:0] hold_data_data;
    logic [3:0]  streak;

    logic        elig_inst;
    logic        elig_data;
    logic        grant_inst;
    logic        grant_data;
    logic        streak_hit;

    // Eligibility and grant; nothing is granted until one
    // full cycle after reset release.
    always_comb begin
        elig_inst  = 1'b0;
        elig_data  = 1'b0;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        streak_hit = (streak == STREAK_MAX);
        elig_inst  = live && bus.inst_req && !hold_inst_valid
                     && !(fly_inst && !bus.inst_resp_ready);
        elig_data  = live && bus.data_req && !hold_data_valid
                     && !(fly_data && !bus.data_resp_ready);
        grant_data = elig_data && !(elig_inst && streak_hit);
        grant_inst = elig_inst && !grant_data;
    end

    // SRAM command mux.
    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.sram_en      = grant_inst | grant_data;
        bus.sram_we      = 4'h0;
        bus.sram_addr    = bus.inst_addr;
        bus.sram_wdata   = bus.data_wdata;
        if (grant_data) begin
            bus.sram_addr = bus.data_addr;
            if (bus.data_wr) begin
                bus.sram_we = bus.data_wstrb;
            end
        end
    end

    // Responses come from the holding buffer first, else
    // straight from the SRAM read port.
    always_comb begin
        bus.inst_data_ok = hold_inst_valid | fly_inst;
        bus.data_data_ok = hold_data_valid | fly_data;
        bus.inst_rdata   = hold_inst_valid ? hold_inst_data
                                           : bus.sram_rdata;
        bus.data_rdata   = hold_data_valid ? hold_data_data
                                           : bus.sram_rdata;
    end

    // Reset-release guard: blocks grants for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // In-flight flags follow the grants by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fly_inst <= 1'b0;
            fly_data <= 1'b0;
        end else begin
            fly_inst <= grant_inst;
            fly_data <= grant_data;
        end
    end

    // Inst holding buffer: catch a response IF cannot take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_inst_valid <= 1'b0;
            hold_inst_data  <= 32'h0;
        end else if (fly_inst && !bus.inst_resp_ready) begin
            hold_inst_valid <= 1'b1;
            hold_inst_data  <= bus.sram_rdata;
        end else if (hold_inst_valid && bus.inst_resp_ready) begin
            hold_inst_valid <= 1'b0;
        end
    end

    // Data holding buffer: catch a response EX cannot take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data_valid <= 1'b0;
            hold_data_data  <= 32'h0;
        end else if (fly_data && !bus.data_resp_ready) begin
            hold_data_valid <= 1'b1;
            hold_data_data  <= bus.sram_rdata;
        end else if (hold_data_valid && bus.data_resp_ready) begin
            hold_data_valid <= 1'b0;
        end
    end

    // Consecutive data grants while a fetch is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 4'h0;
        end else if (grant_inst || !bus.inst_req) begin
            streak <= 4'h0;
        end else if (grant_data && !streak_hit) begin
            streak <= streak + 4'h1;
        end
    end

endmodule
